mux4_rr_arbiter: RTL and testbench

- Shares one output channel between four requesters, each using a valid/ready handshake.
- A round-robin arbiter produces a one-hot grant. That grant drives the 4:1 data select, built as AND-OR gating from &, | and ~.
- The selected word is captured into a one-entry registered output stage.
- Sits in front of any single-consumer resource fed by four producers.

---
 rtl/mux4_rr_arbiter.sv | 108 ++++++++++
 tb/tb_mux4_rr_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux4_rr_arbiter
//
// Shares one output channel between four valid/ready requesters. A
// round-robin arbiter picks one eligible requester per cycle (one-hot grant).
// The grant drives an AND-OR data select, and the selected word is captured
// into a one-entry registered output stage.
//
// Ports:
//   clk                  clock, all state updates on the rising edge
//   rst_n                asynchronous active-low reset
//   req_mask[3:0]        bit i enables requester i (masked -> never granted)
//   dN_valid, dN         requester N word presented / word data (N = 0..3)
//   dN_ready             requester N word accepted this cycle
//   out_valid            output register holds a word
//   out_ready            consumer accepts the output word this cycle
//   out_data             registered selected word
//   out_src              index of the requester that supplied out_data
// -----------------------------------------------------------------------------
module mux4_rr_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req_mask,
  input  logic             d0_valid,
  input  logic             d1_valid,
  input  logic             d2_valid,
  input  logic             d3_valid,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic             d0_ready,
  output logic             d1_ready,
  output logic             d2_ready,
  output logic             d3_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_src
);

  logic [3:0]       valid_vec;
  logic [3:0]       eligible;
  logic [3:0]       grant;
  logic [3:0]       ready_vec;
  logic [1:0]       last_grant;
  logic [1:0]       scan_idx;
  logic             can_load;
  logic             xfer;
  logic [WIDTH-1:0] sel_data;
  logic [1:0]       sel_src;

  assign valid_vec = {d3_valid, d2_valid, d1_valid, d0_valid};
  assign eligible  = valid_vec & req_mask;

  // Scan last_grant+1 .. last_grant+4 (mod 4); first eligible index wins.
  // The 2-bit add wraps naturally, so +4 lands back on last_grant itself.
  always_comb begin
    grant    = 4'b0000;
    scan_idx = last_grant;
    for (int k = 1; k <= 4; k++) begin
      scan_idx = last_grant + 2'(k);
      if ((grant == 4'b0000) && eligible[scan_idx]) begin
        grant[scan_idx] = 1'b1;
      end
    end
  end

  assign can_load = ~out_valid | out_ready;

  // Gating with rst_n keeps every ready low while reset is held, so no
  // handshake can complete in a reset cycle even though the register is empty.
  assign ready_vec = grant & {4{can_load & rst_n}};
  assign d0_ready  = ready_vec[0];
  assign d1_ready  = ready_vec[1];
  assign d2_ready  = ready_vec[2];
  assign d3_ready  = ready_vec[3];

  assign xfer = |(ready_vec & valid_vec);

  assign sel_data = (d0 & {WIDTH{grant[0]}}) |
                    (d1 & {WIDTH{grant[1]}}) |
                    (d2 & {WIDTH{grant[2]}}) |
                    (d3 & {WIDTH{grant[3]}});

  // One-hot to binary encode of the grant.
  assign sel_src = {grant[3] | grant[2], grant[3] | grant[1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_src    <= 2'd0;
      last_grant <= 2'd3;
    end else if (xfer) begin
      // Covers both an empty register and a simultaneous drain-and-load.
      out_valid  <= 1'b1;
      out_data   <= sel_data;
      out_src    <= sel_src;
      last_grant <= sel_src;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux4_rr_arbiter
//
// Scoreboard bench: the stimulus process predicts, from a round-robin
// reference model, which requester is accepted each cycle and pushes the
// expected {data, src} into a queue; a monitor pops and compares on every
// output handshake.
// -----------------------------------------------------------------------------
module tb_mux4_rr_arbiter;

  localparam int W = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    req_mask;
  logic [3:0]    vin;
  logic [W-1:0]  din [4];
  logic [3:0]    rdy;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [1:0]    out_src;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_mask  (req_mask),
    .d0_valid  (vin[0]),
    .d1_valid  (vin[1]),
    .d2_valid  (vin[2]),
    .d3_valid  (vin[3]),
    .d0        (din[0]),
    .d1        (din[1]),
    .d2        (din[2]),
    .d3        (din[3]),
    .d0_ready  (rdy[0]),
    .d1_ready  (rdy[1]),
    .d2_ready  (rdy[2]),
    .d3_ready  (rdy[3]),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src)
  );

  typedef struct {
    logic [W-1:0] d;
    logic [1:0]   s;
  } exp_t;

  exp_t sbq [$];
  exp_t mon_e;

  int   n_vec = 0;
  int   n_err = 0;
  int   m_last;          // model: index of the last accepted requester
  bit   m_ov;            // model: output register occupied
  int   rdy_cnt [4];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: accept only if the output slot is free or draining, then pick
  // the first enabled+valid requester going round from the one after m_last.
  function automatic logic [3:0] exp_ready();
    logic [3:0] r;
    int idx;
    r = 4'b0000;
    if (!m_ov || out_ready) begin
      for (int k = 1; k <= 4; k++) begin
        idx = (m_last + k) % 4;
        if (vin[idx] && req_mask[idx]) begin
          r[idx] = 1'b1;
          break;
        end
      end
    end
    return r;
  endfunction

  // Called just after a rising edge; returns just after the next one.
  task automatic step(input logic [3:0] v, input logic [3:0] m, input logic ordy,
                      output int acc);
    logic [3:0] e;
    exp_t t;
    vin = v;
    req_mask = m;
    out_ready = ordy;
    @(negedge clk); #1;
    check("out_valid", int'(out_valid), int'(m_ov));
    e = exp_ready();
    check("ready", int'(rdy), int'(e));
    acc = -1;
    for (int i = 0; i < 4; i++) begin
      if (rdy[i]) rdy_cnt[i]++;
      if (e[i]) acc = i;
    end
    if (acc >= 0) begin
      t.d = din[acc];
      t.s = 2'(acc);
      sbq.push_back(t);
      m_last = acc;
      m_ov = 1'b1;
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_src", int'(out_src), 0);
    check("rst_ready", int'(rdy), 0);
    @(posedge clk); #1;
    check("rst_ready_held", int'(rdy), 0);
    check("rst_out_valid_held", int'(out_valid), 0);
    sbq.delete();
    m_last = 3;
    m_ov = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 4; i++) rdy_cnt[i] = 0;
  endtask

  // Monitor: every output handshake consumes exactly one predicted word.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_underflow: got word %0d src %0d, expected none", out_data, out_src);
      end else begin
        mon_e = sbq.pop_front();
        check("out_data", int'(out_data), int'(mon_e.d));
        check("out_src", int'(out_src), int'(mon_e.s));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    logic [3:0] pv;
    logic [3:0] rmask;
    logic [W-1:0] held_d;
    logic [1:0]   held_s;

    vin = 4'b0000;
    req_mask = 4'hF;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) din[i] = '0;
    clear_counts();
    rst_n = 1'b0;
    #3;
    check("init_out_valid", int'(out_valid), 0);
    check("init_ready", int'(rdy), 0);
    @(posedge clk); #1;
    m_last = 3;
    m_ov = 1'b0;
    rst_n = 1'b1;

    // Traffic, then reset mid-stream with a word held.
    for (int i = 0; i < 4; i++) din[i] = W'(4'h8 + i);
    step(4'hF, 4'hF, 1'b1, acc);
    step(4'hF, 4'hF, 1'b0, acc);
    vin = 4'hF;
    do_reset();

    // Reset priority: 1,2,3,4 from src 0,1,2,3.
    din[0] = 4'h1; din[1] = 4'h2; din[2] = 4'h3; din[3] = 4'h4;
    for (int n = 0; n < 4; n++) step(4'hF, 4'hF, 1'b1, acc);

    // Round-robin wrap: 8 transfers, each ready exactly twice.
    clear_counts();
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 4; i++) din[i] = W'($urandom);
      step(4'hF, 4'hF, 1'b1, acc);
    end
    for (int i = 0; i < 4; i++) check("rr_ready_count", rdy_cnt[i], 2);

    // Backpressure: three stalled cycles, output stable.
    step(4'hF, 4'hF, 1'b1, acc);
    held_d = out_data;
    held_s = out_src;
    for (int n = 0; n < 3; n++) begin
      step(4'hF, 4'hF, 1'b0, acc);
      check("stall_data", int'(out_data), int'(held_d));
      check("stall_src", int'(out_src), int'(held_s));
    end
    step(4'hF, 4'hF, 1'b1, acc);
    check("post_stall_src", int'(out_src), (int'(held_s) + 1) % 4);

    // Drain, then sparse: d2 alone, then d0 alone back to back.
    step(4'h0, 4'hF, 1'b1, acc);
    step(4'h0, 4'hF, 1'b1, acc);
    din[2] = 4'hA;
    step(4'b0100, 4'hF, 1'b1, acc);
    check("sparse_src2", int'(out_src), 2);
    din[0] = 4'h5;
    step(4'b0001, 4'hF, 1'b1, acc);
    check("sparse_valid", int'(out_valid), 1);
    check("sparse_data5", int'(out_data), 5);
    check("sparse_src0", int'(out_src), 0);

    // Mask out requester 2 for 6 transfers.
    clear_counts();
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 4; i++) din[i] = W'($urandom);
      step(4'hF, 4'b1011, 1'b1, acc);
    end
    check("mask_d2_ready", rdy_cnt[2], 0);
    check("mask_d0_ready", rdy_cnt[0], 2);

    // Drain to empty: single d1 word 7.
    step(4'h0, 4'hF, 1'b1, acc);
    step(4'h0, 4'hF, 1'b1, acc);
    din[1] = 4'h7;
    step(4'b0010, 4'hF, 1'b1, acc);
    check("drain_valid_hi", int'(out_valid), 1);
    step(4'h0, 4'hF, 1'b1, acc);
    check("drain_valid_lo", int'(out_valid), 0);
    step(4'h0, 4'hF, 1'b1, acc);
    check("drain_data_kept", int'(out_data), 7);
    check("drain_src_kept", int'(out_src), 1);

    // Randomized traffic; requesters hold word and valid until accepted.
    pv = 4'b0000;
    rmask = 4'hF;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pv[i] && ($urandom % 2 == 0)) begin
          pv[i] = 1'b1;
          din[i] = W'($urandom);
        end
      end
      if ($urandom % 16 == 0) rmask = 4'($urandom);
      step(pv, rmask, ($urandom % 4) != 0, acc);
      if (acc >= 0) pv[acc] = 1'b0;
    end

    for (int n = 0; n < 3; n++) step(4'h0, 4'hF, 1'b1, acc);
    check("sb_empty", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
